// File: rtl/binarize_pkg.sv
// Shared types and elaboration-time helpers for the streaming pixel binariser.
package binarize_pkg;

  // Threshold source selection, sampled once per frame at start of frame.
  typedef enum logic [1:0] {
    MODE_FIXED     = 2'd0,
    MODE_PROG      = 2'd1,
    MODE_ADAPT     = 2'd2,
    MODE_ADAPT_OFS = 2'd3
  } mode_e;

  // The fixed levels split the pixel range into five equal bands.
  localparam int unsigned NUM_LEVELS    = 4;
  localparam int unsigned LEVEL_DIVISOR = 5;

  // Working width of the saturating helper; pixel widths must stay below it.
  localparam int unsigned SAT_WIDTH = 32;

  // LEVEL(k) = floor(2^width * (k+1) / 5). Evaluated at elaboration only.
  function automatic logic [63:0] level_thresh(input int unsigned k,
                                               input int unsigned width);
    logic [63:0] full;
    full = (64'd1 << width) * 64'(k + 1);
    return full / 64'(LEVEL_DIVISOR);
  endfunction

  // Adds a signed offset to an unsigned base and clamps the result to
  // [0, 2^width-1]. Two guard bits keep the intermediate sum exact.
  function automatic logic [SAT_WIDTH-1:0] sat_add(
      input logic        [SAT_WIDTH-1:0] base,
      input logic signed [SAT_WIDTH-1:0] ofs,
      input int unsigned                 width);
    logic signed [SAT_WIDTH+1:0] sum;
    logic signed [SAT_WIDTH+1:0] max_val;
    logic        [SAT_WIDTH-1:0] result;
    sum     = $signed({2'b00, base}) + $signed({{2{ofs[SAT_WIDTH-1]}}, ofs});
    max_val = $signed(((SAT_WIDTH+2)'(1) << width) - (SAT_WIDTH+2)'(1));
    if (sum < 0) begin
      result = '0;
    end else if (sum > max_val) begin
      result = max_val[SAT_WIDTH-1:0];
    end else begin
      result = sum[SAT_WIDTH-1:0];
    end
    return result;
  endfunction

endpackage

// File: rtl/binarize_stream_frame_mean_acc.sv
// Per-frame luminance accumulator. The sum closes on each start-of-frame
// pixel, which also seeds the next sum. o_mean_next exposes the mean that
// is about to be latched so the threshold logic can use it in the same cycle.
module frame_mean_acc #(
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned LOG2_PIXELS = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  input  logic                   i_sof,
  input  logic [PIXEL_WIDTH-1:0] i_pixel,
  output logic [PIXEL_WIDTH-1:0] o_mean,
  output logic [PIXEL_WIDTH-1:0] o_mean_next
);

  localparam int unsigned ACC_WIDTH = PIXEL_WIDTH + LOG2_PIXELS;

  // Mid-scale is a neutral guess for the mean before any frame completes.
  localparam logic [PIXEL_WIDTH-1:0] MEAN_RESET = {1'b1, {(PIXEL_WIDTH-1){1'b0}}};

  logic [ACC_WIDTH-1:0] r_acc;
  logic [ACC_WIDTH-1:0] w_pixel_ext;
  logic [PIXEL_WIDTH-1:0] r_mean;

  assign w_pixel_ext = {{LOG2_PIXELS{1'b0}}, i_pixel};

  // Dividing by the nominal frame size is just dropping the low bits.
  assign o_mean_next = r_acc[ACC_WIDTH-1:LOG2_PIXELS];
  assign o_mean      = r_mean;

  // Accumulate pixels; on sof publish the closing mean and restart the sum.
  // Oversized frames simply wrap the accumulator.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc  <= '0;
      r_mean <= MEAN_RESET;
    end else if (i_valid) begin
      if (i_sof) begin
        r_mean <= o_mean_next;
        r_acc  <= w_pixel_ext;
      end else begin
        r_acc  <= r_acc + w_pixel_ext;
      end
    end
  end

endmodule

// File: rtl/binarize_stream.sv
// Streaming binariser: pixel > threshold (optionally inverted), two-cycle
// registered pipeline. The threshold source and invert are captured on the
// start-of-frame pixel and held for the rest of the frame.
module binarize_stream
  import binarize_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH        = 8,
  parameter int unsigned LOG2_PIXELS        = 16,
  parameter int unsigned ADAPT_OFFSET_WIDTH = 4
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          valid_in,
  input  logic                          sof_in,
  input  logic [PIXEL_WIDTH-1:0]        pixel_in,
  input  logic [1:0]                    mode_in,
  input  logic [1:0]                    level_in,
  input  logic [PIXEL_WIDTH-1:0]        prog_thresh_in,
  input  logic [ADAPT_OFFSET_WIDTH-1:0] offset_in,
  input  logic                          invert_in,
  output logic                          valid_out,
  output logic                          pixel_out,
  output logic [PIXEL_WIDTH-1:0]        thresh_out,
  output logic [PIXEL_WIDTH-1:0]        mean_out
);

  localparam logic [PIXEL_WIDTH-1:0] LVL0 = PIXEL_WIDTH'(level_thresh(0, PIXEL_WIDTH));
  localparam logic [PIXEL_WIDTH-1:0] LVL1 = PIXEL_WIDTH'(level_thresh(1, PIXEL_WIDTH));
  localparam logic [PIXEL_WIDTH-1:0] LVL2 = PIXEL_WIDTH'(level_thresh(2, PIXEL_WIDTH));
  localparam logic [PIXEL_WIDTH-1:0] LVL3 = PIXEL_WIDTH'(level_thresh(3, PIXEL_WIDTH));

  logic                   w_sof_evt;
  logic [PIXEL_WIDTH-1:0] w_mean_next;
  logic [PIXEL_WIDTH-1:0] w_level_thr;
  logic [PIXEL_WIDTH-1:0] w_mean_ofs;
  logic [PIXEL_WIDTH-1:0] w_thr_new;
  logic [SAT_WIDTH-1:0]   w_ofs_ext;
  logic [SAT_WIDTH-1:0]   w_mean_ext;
  logic [PIXEL_WIDTH-1:0] w_thr_eff;
  logic                   w_inv_eff;

  // Per-frame latched configuration, reduced to what the compare needs.
  logic [PIXEL_WIDTH-1:0] r_thresh;
  logic                   r_invert;

  logic                   r_s1_valid;
  logic [PIXEL_WIDTH-1:0] r_s1_pix;
  logic [PIXEL_WIDTH-1:0] r_s1_thr;
  logic                   r_s1_inv;

  logic                   r_s2_valid;
  logic                   r_s2_pix;

  assign w_sof_evt = valid_in & sof_in;

  frame_mean_acc #(
    .PIXEL_WIDTH (PIXEL_WIDTH),
    .LOG2_PIXELS (LOG2_PIXELS)
  ) u_mean (
    .i_clk       (clk_in),
    .i_rst       (rst_in),
    .i_valid     (valid_in),
    .i_sof       (sof_in),
    .i_pixel     (pixel_in),
    .o_mean      (mean_out),
    .o_mean_next (w_mean_next)
  );

  // Select one of the four constant levels.
  always_comb begin
    w_level_thr = LVL0;
    case (level_in)
      2'd0:    w_level_thr = LVL0;
      2'd1:    w_level_thr = LVL1;
      2'd2:    w_level_thr = LVL2;
      default: w_level_thr = LVL3;
    endcase
  end

  // Adaptive threshold with signed offset, clamped to the pixel range.
  assign w_ofs_ext  = {{(SAT_WIDTH-ADAPT_OFFSET_WIDTH){offset_in[ADAPT_OFFSET_WIDTH-1]}}, offset_in};
  assign w_mean_ext = {{(SAT_WIDTH-PIXEL_WIDTH){1'b0}}, w_mean_next};
  assign w_mean_ofs = PIXEL_WIDTH'(sat_add(w_mean_ext, $signed(w_ofs_ext), PIXEL_WIDTH));

  // Threshold that takes effect if this cycle is a start of frame. Adaptive
  // modes use the mean of the frame that this sof closes.
  always_comb begin
    w_thr_new = w_level_thr;
    case (mode_e'(mode_in))
      MODE_FIXED:     w_thr_new = w_level_thr;
      MODE_PROG:      w_thr_new = prog_thresh_in;
      MODE_ADAPT:     w_thr_new = w_mean_next;
      MODE_ADAPT_OFS: w_thr_new = w_mean_ofs;
      default:        w_thr_new = w_level_thr;
    endcase
  end

  // The sof pixel is judged against its own frame's settings, so bypass
  // the latch on that cycle.
  assign w_thr_eff = w_sof_evt ? w_thr_new : r_thresh;
  assign w_inv_eff = w_sof_evt ? invert_in : r_invert;

  // Capture threshold and invert once per frame; ignore config otherwise.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_thresh <= LVL0;
      r_invert <= 1'b0;
    end else if (w_sof_evt) begin
      r_thresh <= w_thr_new;
      r_invert <= invert_in;
    end
  end

  // Stage 1: register the pixel together with the settings it must use.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_s1_valid <= 1'b0;
      r_s1_pix   <= '0;
      r_s1_thr   <= LVL0;
      r_s1_inv   <= 1'b0;
    end else begin
      r_s1_valid <= valid_in;
      r_s1_pix   <= pixel_in;
      r_s1_thr   <= w_thr_eff;
      r_s1_inv   <= w_inv_eff;
    end
  end

  // Stage 2: strict compare, optional inversion; idle cycles output 0.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_s2_valid <= 1'b0;
      r_s2_pix   <= 1'b0;
    end else begin
      r_s2_valid <= r_s1_valid;
      r_s2_pix   <= r_s1_valid & ((r_s1_pix > r_s1_thr) ^ r_s1_inv);
    end
  end

  assign valid_out  = r_s2_valid;
  assign pixel_out  = r_s2_pix;
  assign thresh_out = r_thresh;

endmodule

// File: doc/binarize_stream.md
Name: binarize_stream

Overview:
- Streaming pixel binariser for the camera→detection path.
- Converts PIXEL_WIDTH-bit luminance pixels into 1-bit foreground/background.
- Threshold source is selectable: one of four fixed fractional levels, a programmable register, or an adaptive threshold equal to the mean luminance of the previous frame.
- Registered two-stage pipeline with valid qualification. Configuration is sampled once per frame so the threshold never changes mid-frame.

Parameters:
- PIXEL_WIDTH, 8, bits per input pixel (≥2).
- LOG2_PIXELS, 16, log2 of nominal pixels per frame. Mean = frame sum >> LOG2_PIXELS.
- ADAPT_OFFSET_WIDTH, 4, width of signed offset added to the adaptive mean.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- valid_in  input  1  pixel_in/sof_in valid this cycle
- sof_in  input  1  start of frame; meaningful only with valid_in, marks first pixel of frame
- pixel_in  input  PIXEL_WIDTH  unsigned luminance
- mode_in  input  2  0=fixed level, 1=programmable, 2=adaptive mean, 3=adaptive mean+offset
- level_in  input  2  fixed-level index k (mode 0)
- prog_thresh_in  input  PIXEL_WIDTH  threshold for mode 1
- offset_in  input  ADAPT_OFFSET_WIDTH  signed offset for mode 3
- invert_in  input  1  1: output = NOT(compare)
- valid_out  output  1  pixel_out valid
- pixel_out  output  1  binarised pixel
- thresh_out  output  PIXEL_WIDTH  threshold in force for current frame
- mean_out  output  PIXEL_WIDTH  mean of last completed frame

Behaviour:
- Reset (sync, rst_in=1 at clk edge):
  - valid_out=0, pixel_out=0.
  - thresh_out = LEVEL(0).
  - mean_out = 2^(PIXEL_WIDTH-1).
  - Accumulator=0; latched config = mode 0, level 0, invert 0.
  - Reset mid-frame discards the partial sum. Pixels in the pipeline are dropped: valid_out=0 on the cycle after reset.
- Fixed levels: LEVEL(k) = floor(2^PIXEL_WIDTH*(k+1)/5), k=0..3. For W=8: 51,102,153,204. These are elaboration-time constants.
- Compare: output 1 iff pixel > threshold (strict), then XOR invert.
- Frame statistics:
  - Accumulator width = PIXEL_WIDTH+LOG2_PIXELS, unsigned. It wraps silently if a frame exceeds 2^LOG2_PIXELS pixels.
  - On valid_in & !sof_in: acc += pixel_in.
  - On valid_in & sof_in: mean_out <= acc >> LOG2_PIXELS (truncate), and acc <= pixel_in. The new pixel is the first of the new sum.
  - A frame shorter than nominal yields a proportionally low mean; no correction is applied.
- Per-frame config latch, on valid_in & sof_in:
  - mode, level, prog_thresh, offset and invert are captured.
  - thresh_out updates from these: mode 0 → LEVEL(level); 1 → prog_thresh; 2 → new mean; 3 → new mean + sign-extended offset, saturated to [0, 2^W-1].
  - The new threshold and invert apply to the sof pixel itself.
  - Config inputs are ignored on all other cycles.
  - Adaptive modes use the mean produced at this same sof (the previous frame's sum).
- Pipeline, latency exactly 2 cycles:
  - Stage 1 registers pixel, valid and the effective threshold/invert. On sof the effective values are the freshly computed ones, bypassing the latch.
  - Stage 2 registers the compare result.
  - valid_out(t+2) = valid_in(t). Gaps in valid_in are preserved.
- No backpressure; the downstream consumer must accept every valid_out.
- sof_in with valid_in=0 is ignored.
- Back-to-back sof pixels are legal: each closes a one-pixel frame.

Decomposition:
- Package binarize_pkg:
  - Mode enum (MODE_FIXED, MODE_PROG, MODE_ADAPT, MODE_ADAPT_OFS).
  - Function level_thresh(k, width) returning LEVEL(k).
  - Saturating-add helper.
- One sub-module, frame_mean_acc: accumulator plus sof latching of mean_out. The top keeps config latch, threshold mux and compare pipeline.

Test Plan:
- Reset then mode 0, level 2, sof, pixels 153,154,0,255 (W=8) → after 2 cycles pixel_out 0,1,0,1; thresh_out=153.
- Mode 1, prog_thresh=10, invert=1, pixels 10,11 → 1,0. Change prog_thresh to 200 mid-frame → outputs unchanged until next sof.
- LOG2_PIXELS=2, mode 2: frame pixels 0,100,200,100 then sof → mean_out=100, thresh_out=100. Next frame pixel 101 → 1, pixel 100 → 0.
- Mode 3, offset=-8 with previous mean 4 → thresh_out saturates to 0. Offset=+7 with mean 252 → saturates to 255.
- Valid gaps: valid_in pattern 1,0,1,1 → valid_out identical pattern delayed exactly 2 cycles.
- Assert rst_in mid-frame with 2 pixels in flight → valid_out=0 next cycle; mean_out=128; thresh_out=51.
